derandomizer: RTL and testbench

DERANDOMIZER -- requirements
Module: derandomizer

---
 rtl/derand_pkg.sv | 43 ++++
 rtl/gold_seq_gen.sv | 42 ++++
 rtl/derandomizer.sv | 119 +++++++++++
 tb/tb_derandomizer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/derand_pkg.sv
// Shared constants, types and helpers for the derandomizer and its Gold sequence generator.
// The early-SOF error output is built in only when DERAND_SYNC_ERR_EN is defined.
package derand_pkg;

  localparam int LFSR_W = 18;
  localparam logic [LFSR_W-1:0] X_INIT = 18'h00001;
  localparam logic [LFSR_W-1:0] Y_INIT = 18'h3FFFF;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  typedef enum logic [1:0] {ROT_0, ROT_90, ROT_180, ROT_270} rot_t;

  function automatic logic [LFSR_W-1:0] x_step(input logic [LFSR_W-1:0] x);
    return {x[7] ^ x[0], x[17:1]};
  endfunction

  function automatic logic [LFSR_W-1:0] y_step(input logic [LFSR_W-1:0] y);
    return {y[10] ^ y[7] ^ y[5] ^ y[0], y[17:1]};
  endfunction

  // Rotation code R = 2*zb + za taken from the current LFSR pair.
  function automatic rot_t gold_rot(input logic [LFSR_W-1:0] x, input logic [LFSR_W-1:0] y);
    logic za;
    logic zb;
    za = x[0] ^ y[0];
    zb = x[4] ^ x[6] ^ x[15] ^ y[5] ^ y[6] ^ y[8] ^ y[9] ^ y[10] ^
         y[11] ^ y[12] ^ y[13] ^ y[14] ^ y[15];
    return rot_t'({zb, za});
  endfunction

  // Undo a +R*90 degree rotation of a hard QPSK symbol {i, q}.
  function automatic logic [1:0] derotate(input logic [1:0] sym, input rot_t r);
    logic [1:0] res;
    case (r)
      ROT_0:   res = sym;
      ROT_90:  res = {sym[0], ~sym[1]};
      ROT_180: res = {~sym[1], ~sym[0]};
      default: res = {~sym[0], sym[1]};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/gold_seq_gen.sv
// Gold sequence generator: x/y LFSR pair with load/step controls and the per-symbol rotation code.
module gold_seq_gen
  import derand_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_load,
  input  logic       i_step,
  output logic [1:0] o_rot
);

  logic [LFSR_W-1:0] x_q;
  logic [LFSR_W-1:0] x_d;
  logic [LFSR_W-1:0] y_q;
  logic [LFSR_W-1:0] y_d;

  // A load consumes the init state for the current symbol, so the stored state is already one step on.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (i_load) begin
      x_d = x_step(X_INIT);
      y_d = y_step(Y_INIT);
    end else if (i_step) begin
      x_d = x_step(x_q);
      y_d = y_step(y_q);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      x_q <= X_INIT;
      y_q <= Y_INIT;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign o_rot = i_load ? gold_rot(X_INIT, Y_INIT) : gold_rot(x_q, y_q);

endmodule

// File: rtl/derandomizer.sv
// CCSDS Gold-sequence QPSK derandomizer with frame tracking and a single registered output stage.
// Define DERAND_SYNC_ERR_EN to enable the o_sync_err pulse on an early start-of-frame.
module derandomizer
  import derand_pkg::*;
#(
  parameter int FRAME_LEN = 16200
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic [1:0] i_data,
  input  logic       i_sof,
  output logic       o_valid,
  input  logic       i_ready,
  output logic [1:0] o_data,
  output logic       o_sof,
  output logic       o_eof,
  output logic       o_sync_err
);

  localparam logic [15:0] LAST_CNT = 16'(FRAME_LEN - 1);

  state_t      state_q;
  state_t      state_d;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic        valid_q;
  logic        valid_d;
  logic [1:0]  data_q;
  logic [1:0]  data_d;
  logic        sof_q;
  logic        sof_d;
  logic        eof_q;
  logic        eof_d;
  logic        sync_err_q;
  logic        sync_err_d;

  logic       accept;
  logic       load;
  logic       step;
  logic [1:0] rot;

  assign o_ready = ~valid_q | i_ready;
  assign accept  = i_valid & o_ready;
  assign load    = accept & i_sof;
  assign step    = accept & ~i_sof & (state_q == ST_RUN);

  gold_seq_gen u_gold (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_load (load),
    .i_step (step),
    .o_rot  (rot)
  );

  // The output register holds while stalled; it only changes on a new accept or a downstream take.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    valid_d    = valid_q & ~i_ready;
    data_d     = data_q;
    sof_d      = sof_q;
    eof_d      = eof_q;
    sync_err_d = 1'b0;
    if (load) begin
      state_d = ST_RUN;
      cnt_d   = 16'd1;
      valid_d = 1'b1;
      data_d  = derotate(i_data, rot_t'(rot));
      sof_d   = 1'b1;
      eof_d   = 1'b0;
`ifdef DERAND_SYNC_ERR_EN
      sync_err_d = (state_q == ST_RUN);
`else
      sync_err_d = 1'b0;
`endif
    end else if (step) begin
      valid_d = 1'b1;
      data_d  = derotate(i_data, rot_t'(rot));
      sof_d   = 1'b0;
      if (cnt_q == LAST_CNT) begin
        state_d = ST_IDLE;
        cnt_d   = 16'd0;
        eof_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + 16'd1;
        eof_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 16'd0;
      valid_q    <= 1'b0;
      data_q     <= 2'b00;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      sof_q      <= sof_d;
      eof_q      <= eof_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign o_valid    = valid_q;
  assign o_data     = data_q;
  assign o_sof      = sof_q;
  assign o_eof      = eof_q;
  assign o_sync_err = sync_err_q;

endmodule

// File: tb/tb_derandomizer.sv
// Directed bench for derandomizer: a FRAME_LEN=4 instance for frame/sync/backpressure cases
// and a default-length instance for a full randomized frame and a mid-frame reset.
module tb_derandomizer;

  logic       clk = 1'b0;
  logic       i_reset;
  logic       i_valid;
  logic       i_sof;
  logic       i_ready;
  logic [1:0] i_data;

  logic       a_ready, a_valid, a_sof, a_eof, a_serr;
  logic [1:0] a_data;
  logic       f_ready, f_valid, f_sof, f_eof, f_serr;
  logic [1:0] f_data;

  int checks   = 0;
  int failures = 0;
  int xfers    = 0;

  logic        mon_en = 1'b0;
  logic [4:0]  exp_q[$];
  logic [17:0] mx;
  logic [17:0] my;

`ifdef DERAND_SYNC_ERR_EN
  localparam logic SERR_ON = 1'b1;
`else
  localparam logic SERR_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  derandomizer #(.FRAME_LEN(4)) dut4 (
    .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(a_ready),
    .i_data(i_data), .i_sof(i_sof), .o_valid(a_valid), .i_ready(i_ready),
    .o_data(a_data), .o_sof(a_sof), .o_eof(a_eof), .o_sync_err(a_serr)
  );

  derandomizer dutf (
    .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(f_ready),
    .i_data(i_data), .i_sof(i_sof), .o_valid(f_valid), .i_ready(i_ready),
    .o_data(f_data), .o_sof(f_sof), .o_eof(f_eof), .o_sync_err(f_serr)
  );

  function automatic logic [1:0] gold_r(input logic [17:0] x, input logic [17:0] y);
    logic za, zb;
    za = x[0] ^ y[0];
    zb = x[4] ^ x[6] ^ x[15] ^ y[5] ^ y[6] ^ y[8] ^ y[9] ^ y[10] ^
         y[11] ^ y[12] ^ y[13] ^ y[14] ^ y[15];
    return {zb, za};
  endfunction

  // Forward rotation by +R*90 degrees, used to build scrambled stimulus from known symbols.
  function automatic logic [1:0] scramble(input logic [1:0] d, input logic [1:0] r);
    logic [1:0] s;
    case (r)
      2'd0:    s = d;
      2'd1:    s = {~d[0], d[1]};
      2'd2:    s = ~d;
      default: s = {d[0], ~d[1]};
    endcase
    return s;
  endfunction

  task automatic model_start();
    mx = 18'h00001;
    my = 18'h3FFFF;
  endtask

  task automatic model_next(output logic [1:0] r);
    r  = gold_r(mx, my);
    mx = {mx[7] ^ mx[0], mx[17:1]};
    my = {my[10] ^ my[7] ^ my[5] ^ my[0], my[17:1]};
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic sof, input logic [1:0] d);
    i_valid = 1'b1;
    i_sof   = sof;
    i_data  = d;
    tick();
  endtask

  task automatic idle();
    i_valid = 1'b0;
    i_sof   = 1'b0;
    tick();
  endtask

  task automatic checkOutput(input string tag, input logic v, input logic [1:0] d,
                             input logic s, input logic e, input logic se);
    chk({tag, ".valid"}, a_valid, v);
    if (v) begin
      chk({tag, ".data"}, a_data, d);
      chk({tag, ".sof"}, a_sof, s);
      chk({tag, ".eof"}, a_eof, e);
    end
    chk({tag, ".serr"}, a_serr, se);
  endtask

  task automatic frameSym(input logic sof, input logic [1:0] orig, input logic eofx,
                          input logic serrx, input string tag);
    logic [1:0] r;
    if (sof) model_start();
    model_next(r);
    applyStimulus(sof, scramble(orig, r));
    checkOutput(tag, 1'b1, orig, sof, eofx, serrx);
  endtask

  // One symbol into the full-length instance under random downstream backpressure.
  task automatic streamSym(input logic sof, input logic [1:0] orig, input logic eofx);
    logic [1:0] r;
    logic acc;
    int n;
    if (sof) model_start();
    model_next(r);
    i_valid = 1'b1;
    i_sof   = sof;
    i_data  = scramble(orig, r);
    acc = 1'b0;
    n = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = f_ready;
      if (acc) exp_q.push_back({orig, sof, eofx, 1'b0});
      @(posedge clk);
      #1;
      i_ready = ($urandom_range(0, 3) != 0);
      n++;
    end
    if (!acc) chk("stream.accept", acc, 1);
    i_valid = 1'b0;
    i_sof   = 1'b0;
    if ($urandom_range(0, 4) == 0) tick();
  endtask

  task automatic drain(input string tag, input int exp_xfers);
    int n;
    i_valid = 1'b0;
    i_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    tick();
    chk({tag, ".pending"}, exp_q.size(), 0);
    chk({tag, ".xfers"}, xfers, exp_xfers);
  endtask

  always @(negedge clk) begin
    if (mon_en && f_valid && i_ready) begin
      logic [4:0] e;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 5'bxxxxx;
      chk("mon.xfer", {f_data, f_sof, f_eof, f_serr}, e);
      xfers++;
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0] r;
    i_reset = 1'b1;
    i_valid = 1'b0;
    i_sof   = 1'b0;
    i_data  = 2'b00;
    i_ready = 1'b1;
    tick(); tick(); tick();
    i_reset = 1'b0;
    chk("rst.valid", a_valid, 0);
    chk("rst.data", a_data, 0);
    chk("rst.sof", a_sof, 0);
    chk("rst.eof", a_eof, 0);
    chk("rst.serr", a_serr, 0);
    chk("rst.ready", a_ready, 1);
    chk("rst.f_valid", f_valid, 0);

    $display("[TB] first symbols after reset");
    applyStimulus(1'b1, 2'b00);
    checkOutput("init.s0", 1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'b00);
    checkOutput("init.s1", 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    model_start();
    model_next(r);
    model_next(r);
    frameSym(1'b0, 2'b10, 1'b0, 1'b0, "f1.s2");
    frameSym(1'b0, 2'b11, 1'b1, 1'b0, "f1.s3");
    applyStimulus(1'b0, 2'b01);
    checkOutput("f1.drop", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    idle();

    $display("[TB] back-to-back frames and early sof");
    frameSym(1'b1, 2'b01, 1'b0, 1'b0, "f2.s0");
    frameSym(1'b0, 2'b10, 1'b0, 1'b0, "f2.s1");
    frameSym(1'b0, 2'b00, 1'b0, 1'b0, "f2.s2");
    frameSym(1'b0, 2'b11, 1'b1, 1'b0, "f2.s3");
    frameSym(1'b1, 2'b10, 1'b0, 1'b0, "f3.s0");
    frameSym(1'b0, 2'b11, 1'b0, 1'b0, "f3.s1");
    frameSym(1'b1, 2'b01, 1'b0, SERR_ON, "f3.resync");
    frameSym(1'b0, 2'b00, 1'b0, 1'b0, "f3.r1");
    frameSym(1'b0, 2'b01, 1'b0, 1'b0, "f3.r2");
    frameSym(1'b0, 2'b10, 1'b1, 1'b0, "f3.r3");
    idle();

    $display("[TB] downstream stall");
    frameSym(1'b1, 2'b11, 1'b0, 1'b0, "bp.s0");
    model_next(r);
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_sof   = 1'b0;
    i_data  = scramble(2'b10, r);
    #1;
    chk("bp.ready0", a_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp.hold.valid", a_valid, 1);
      chk("bp.hold.data", a_data, 2'b11);
      chk("bp.hold.sof", a_sof, 1);
      chk("bp.hold.ready", a_ready, 0);
    end
    i_ready = 1'b1;
    tick();
    checkOutput("bp.resume", 1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
    frameSym(1'b0, 2'b01, 1'b0, 1'b0, "bp.s2");
    frameSym(1'b0, 2'b00, 1'b1, 1'b0, "bp.s3");
    idle();

    $display("[TB] full frame with random backpressure");
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    exp_q.delete();
    xfers = 0;
    mon_en = 1'b1;
    for (int k = 0; k < 16200; k++) begin
      streamSym(k == 0, 2'($urandom_range(0, 3)), k == 16199);
    end
    drain("full", 16200);

    $display("[TB] reset in the middle of a frame");
    xfers = 0;
    for (int k = 0; k < 100; k++) begin
      streamSym(k == 0, 2'($urandom_range(0, 3)), 1'b0);
    end
    mon_en  = 1'b0;
    i_ready = 1'b0;
    i_reset = 1'b1;
    i_valid = 1'b1;
    i_sof   = 1'b0;
    i_data  = 2'b10;
    tick();
    chk("rstmid.valid", f_valid, 0);
    chk("rstmid.ready", f_ready, 1);
    i_reset = 1'b0;
    i_valid = 1'b0;
    exp_q.delete();
    tick();
    chk("rstmid.idle", f_valid, 0);
    xfers  = 0;
    mon_en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      streamSym(k == 0, 2'($urandom_range(0, 3)), 1'b0);
    end
    drain("rstmid", 20);
    mon_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
